// File: rtl/riscv_fetch.sv
// Instruction fetch stage: single-outstanding word read, held instruction for decode.
// Optional FETCH_MISALIGN_CHECK_EN: fault on misaligned PC instead of masking pc[1:0].
module riscv_fetch #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [4:0]  rs1_index,
    output logic [4:0]  rs2_index,
    output logic        fetch_fault,
    output logic        fetch_misaligned
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, FAULT} state_t;

    localparam bit          TIMEOUT_EN   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT - 1);

    state_t      state_reg;
    logic        mem_req_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] instr_reg;
    logic [31:0] instr_pc_reg;
    logic        instr_valid_reg;
    logic        fault_reg;
    logic [31:0] count_reg;
    logic        discard_reg;
    logic [31:0] pc_word;

    assign pc_word = {pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_reg;
    assign fetch_misaligned = misaligned_reg;
`else
    assign fetch_misaligned = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= 32'h0;
            instr_reg       <= RESET_INSTR;
            instr_pc_reg    <= 32'h0;
            instr_valid_reg <= 1'b0;
            fault_reg       <= 1'b0;
            count_reg       <= 32'h0;
            discard_reg     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch_en && !flush) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            instr_pc_reg   <= pc;
                            fault_reg      <= 1'b1;
                            misaligned_reg <= 1'b1;
                            state_reg      <= FAULT;
                        end else
`endif
                        begin
                            state_reg    <= BUSY;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= pc_word;
                            instr_pc_reg <= pc_word;
                            count_reg    <= 32'h0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req_reg <= 1'b0;
                        discard_reg <= 1'b0;
                        // A flush seen now or earlier in this transaction kills the data
                        if (discard_reg || flush) begin
                            state_reg <= IDLE;
                        end else begin
                            instr_reg       <= mem_rdata;
                            instr_valid_reg <= 1'b1;
                            state_reg       <= HOLD;
                        end
                    end else begin
                        if (flush) begin
                            discard_reg <= 1'b1;
                        end
                        if (count_reg != 32'hFFFF_FFFF) begin
                            count_reg <= count_reg + 32'd1;
                        end
                        if (TIMEOUT_EN && (count_reg == TIMEOUT_LAST)) begin
                            mem_req_reg <= 1'b0;
                            fault_reg   <= 1'b1;
                            discard_reg <= 1'b0;
                            state_reg   <= FAULT;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        instr_valid_reg <= 1'b0;
                        instr_reg       <= RESET_INSTR;
                        state_reg       <= IDLE;
                    end else if (instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                FAULT: begin
                    if (flush) begin
                        fault_reg <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                        misaligned_reg <= 1'b0;
`endif
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign fetch_fault = fault_reg;

    // Register-file index fields come straight off the held word
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_rs_index
            assign rs1_index[gi] = instr_reg[15 + gi];
            assign rs2_index[gi] = instr_reg[20 + gi];
        end
    endgenerate

endmodule
